// File: rtl/result_accum.sv
// Sums a stream of tagged arithmetic results into blocks of BLOCK_LEN same-tag words
// and presents each finished block as one summary word over a valid/ready handshake.
module result_accum #(
    parameter int RES_W     = 40,
    parameter int ACC_W     = 48,
    parameter int BLOCK_LEN = 4,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sel,
    input  logic [RES_W-1:0] in_result,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic [CNT_W-1:0] out_count,
    output logic             out_sel,
    output logic             out_ovf
);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        HOLD
    } state_t;

    state_t           state;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic             cur_sel;
    logic             ovf;

    logic             accept;
    logic [ACC_W:0]   sum_ext;
    logic [CNT_W-1:0] cnt_inc;
    logic             last;

    // A word with a different tag is refused so it stays pending upstream.
    always_comb begin
        in_ready = (state == IDLE) || ((state == ACCUM) && (in_sel == cur_sel));
    end

    assign accept  = in_valid && in_ready;
    assign sum_ext = {1'b0, acc} + {1'b0, ACC_W'(in_result)};
    assign cnt_inc = cnt + CNT_W'(1);
    assign last    = (cnt_inc == CNT_W'(BLOCK_LEN));

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state   <= IDLE;
            acc     <= '0;
            cnt     <= '0;
            cur_sel <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        acc     <= ACC_W'(in_result);
                        cnt     <= CNT_W'(1);
                        cur_sel <= in_sel;
                        ovf     <= 1'b0;
                        state   <= (BLOCK_LEN == 1) ? HOLD : ACCUM;
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        acc <= sum_ext[ACC_W-1:0];
                        cnt <= cnt_inc;
                        ovf <= ovf | sum_ext[ACC_W];
                        if (last || flush) state <= HOLD;
                    end else if (in_valid || flush) begin
                        // in_valid without accept means a tag mismatch: close the partial block
                        state <= HOLD;
                    end
                end
                HOLD: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign out_valid = (state == HOLD);
    assign out_sum   = acc;
    assign out_count = cnt;
    assign out_sel   = cur_sel;
    assign out_ovf   = ovf;

endmodule
